tlc_conflict_monitor: RTL and testbench
=======================================

// Module: tlc_conflict_monitor
// PURPOSE
//  Lamp-side checker for the 4-way traffic light controller. It samples the controller's R/G/O lamp buses,
//  detects unsafe or illegal aspects and latches a fault. On a fault it overrides the lamp drive with an
//  all-red safe aspect. It sits between the controller outputs and the lamp drivers.
// PARAMETERS
//  MIN_GREEN   5  minimum cycles a side must show green before leaving it
//  MIN_AMBER   3  minimum cycles a side must show amber before leaving it
//  MIN_ALLRED  4  all-red cycles required in RECOVER before returning to MONITOR
//  FLASH_HALF  4  half-period of the fault flash, in cycles (only used with FLASH_EN)
//  CW          8  width of the per-side phase counters and the recovery timer
// PORTS
//  clkdiv      in   1  single clock; all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  R           in   4  red lamp per side (bit i = side i), from the controller
//  G           in   4  green lamp per side
//  O           in   4  amber lamp per side
//  clr         in   1  fault acknowledge; sampled only in FAULT
//  Ro          out  4  red lamp drive to the lamps
//  Go          out  4  green lamp drive
//  Oo          out  4  amber lamp drive
//  fault       out  1  1 while in FAULT
//  fault_code  out  3  first violation code, latched; 0 = none
//  fault_side  out  2  side index of the latched violation
// BEHAVIOUR
//  States: RECOVER, MONITOR, FAULT. Reset enters RECOVER with the timer cleared.
//  Reset values: Ro=4'b1111, Go=0, Oo=0, fault=0, fault_code=0, fault_side=0.
//  The block holds the previous lamps in registers pR/pG/pO. Reset sets them to all-red.
//  Per-side counters count consecutive cycles in the current aspect. The first cycle of an aspect counts 1.
//  Counters saturate at 2^CW-1.
//  MONITOR checks every cycle, comparing the current inputs against pR/pG/pO:
//   1 MULTI        : a side shows more than one lamp.
//   2 DARK         : a side shows no lamp.
//   3 CONFLICT     : more than one side shows G or O. Side reported = lowest such index.
//   4 SKIP_AMBER   : a side goes G -> R.
//   5 SHORT_AMBER  : a side leaves O while its counter is < MIN_AMBER.
//   6 SHORT_GREEN  : a side leaves G while its counter is < MIN_GREEN.
//   7 BAD_ORDER    : a side goes R -> O or O -> G.
//  Simultaneous violations: the lowest code wins. Within that code, the lowest side index wins.
//  Latency: a violation in the inputs at edge n gives fault=1 and the latched code/side at edge n+1.
//  The code and side stay frozen until the block leaves FAULT.
//  In MONITOR, Ro/Go/Oo equal R/G/O registered, so the drive lags the inputs by 1 cycle.
//  FAULT: Go=Oo=0 and Ro=all-red aspect. Checks are disabled. clr=1 -> RECOVER next cycle, with the timer
//  cleared, fault=0 and fault_code/fault_side=0.
//  RECOVER: drive is all-red (Ro=1111, Go=Oo=0). No violation checks. The timer increments on each cycle
//  where the inputs are exactly R=1111, G=0, O=0, and clears on any other cycle.
//  When timer == MIN_ALLRED, go to MONITOR next cycle. Side counters then restart from the all-red aspect.
//  clr outside FAULT is ignored.
//  rst has priority over everything, including mid-FAULT and mid-RECOVER. It forces RECOVER and the
//  reset values.
// CONFIGURATION
//  FLASH_EN defined  : in FAULT, Ro toggles between 4'b1111 and 4'b0000 every FLASH_HALF cycles. Ro is 1111
//                      on the first FAULT cycle. The flash counter clears on FAULT entry.
//  FLASH_EN undefined: in FAULT, Ro is steady 4'b1111. No flash counter is built.
// TESTING
//  T1 rst for 2 cycles, then all-red for 4 cycles -> MONITOR. Side0 G 5 cycles, O 3, R; then side1 the same
//     -> fault stays 0; Go/Oo/Ro track the inputs 1 cycle late.
//  T2 In MONITOR, drive G=4'b0101 with R=4'b1010 -> next cycle fault=1, fault_code=3, fault_side=0,
//     Ro=1111, Go=0.
//  T3 Side2: G for 6 cycles, then R directly -> fault_code=4, fault_side=2.
//     Repeat with O held only 2 cycles -> fault_code=5.
//  T4 Side1 shows R=1, G=1 simultaneously -> fault_code=1 (MULTI beats CONFLICT), fault_side=1.
//  T5 In FAULT: clr=1 for 1 cycle, then all-red with one dark cycle after 2 cycles -> timer restarts.
//     MONITOR is reached only after 4 consecutive all-red cycles; fault_code=0.
//  T6 FLASH_EN, FLASH_HALF=4: force CONFLICT -> Ro = 1111 x4, 0000 x4, 1111... Assert rst mid-FAULT
//     -> Ro=1111, fault=0 next cycle.

Source files
------------

// File: rtl/tlc_conflict_monitor_if.sv
// Lamp bus between the traffic light controller and the conflict monitor.
// master = controller side, slave = monitor side.
interface tlc_conflict_monitor_if;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] O;
    logic       clr;
    logic [3:0] Ro;
    logic [3:0] Go;
    logic [3:0] Oo;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_side;

    modport master (
        output R, G, O, clr,
        input  Ro, Go, Oo, fault, fault_code, fault_side
    );

    modport slave (
        input  R, G, O, clr,
        output Ro, Go, Oo, fault, fault_code, fault_side
    );
endinterface

// File: rtl/tlc_conflict_monitor.sv
// Lamp-side safety checker: latches the first illegal aspect and forces all-red.
// Optional macro FLASH_EN: red lamps flash with half-period FLASH_HALF in FAULT.
module tlc_conflict_monitor #(
    parameter int MIN_GREEN  = 5,
    parameter int MIN_AMBER  = 3,
    parameter int MIN_ALLRED = 4,
`ifdef FLASH_EN
    parameter int FLASH_HALF = 4,
`endif
    parameter int CW         = 8
) (
    input logic                   clkdiv,
    input logic                   rst,
    tlc_conflict_monitor_if.slave bus
);

    localparam logic [CW-1:0] MIN_G   = CW'(MIN_GREEN);
    localparam logic [CW-1:0] MIN_A   = CW'(MIN_AMBER);
    localparam logic [CW-1:0] MIN_R   = CW'(MIN_ALLRED);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [3:0]    ALL     = 4'hF;

    typedef enum logic [1:0] {
        RECOVER,
        MONITOR,
        FAULT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] timer;
    logic [CW-1:0] cnt [4];
    logic [3:0]    pR;
    logic [3:0]    pG;
    logic [3:0]    pO;
    logic [3:0]    ro_q;
    logic [3:0]    go_q;
    logic [3:0]    oo_q;
    logic          fault_q;
    logic [2:0]    code_q;
    logic [1:0]    side_q;
    logic [2:0]    viol_code;
    logic [1:0]    viol_side;
    logic [3:0]    fault_ro;
    logic          all_red;
    logic          stay_mon;
    logic          enter_fault;

    logic [3:0] multi;
    logic [3:0] dark;
    logic [3:0] go_any;
    logic [3:0] conflict;
    logic [3:0] skip;
    logic [3:0] short_o;
    logic [3:0] short_g;
    logic [3:0] bad_ord;

    function automatic logic [1:0] low_side(input logic [3:0] v);
        low_side = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) low_side = 2'(i);
        end
    endfunction

    assign all_red = (bus.R == ALL) && (bus.G == 4'h0) && (bus.O == 4'h0);

    // pR/pG/pO are always a legal aspect here, so single-bit transition tests suffice.
    always_comb begin
        multi   = '0;
        dark    = '0;
        skip    = '0;
        short_o = '0;
        short_g = '0;
        bad_ord = '0;
        for (int i = 0; i < 4; i++) begin
            multi[i]   = (bus.R[i] & bus.G[i]) | (bus.R[i] & bus.O[i])
                       | (bus.G[i] & bus.O[i]);
            dark[i]    = ~(bus.R[i] | bus.G[i] | bus.O[i]);
            skip[i]    = pG[i] & bus.R[i];
            short_o[i] = pO[i] & ~bus.O[i] & (cnt[i] < MIN_A);
            short_g[i] = pG[i] & ~bus.G[i] & (cnt[i] < MIN_G);
            bad_ord[i] = (pR[i] & bus.O[i]) | (pO[i] & bus.G[i]);
        end
        go_any   = bus.G | bus.O;
        conflict = ($countones(go_any) > 1) ? go_any : 4'h0;
    end

    always_comb begin
        viol_code = 3'd0;
        viol_side = 2'd0;
        if (|multi) begin
            viol_code = 3'd1;
            viol_side = low_side(multi);
        end else if (|dark) begin
            viol_code = 3'd2;
            viol_side = low_side(dark);
        end else if (|conflict) begin
            viol_code = 3'd3;
            viol_side = low_side(conflict);
        end else if (|skip) begin
            viol_code = 3'd4;
            viol_side = low_side(skip);
        end else if (|short_o) begin
            viol_code = 3'd5;
            viol_side = low_side(short_o);
        end else if (|short_g) begin
            viol_code = 3'd6;
            viol_side = low_side(short_g);
        end else if (|bad_ord) begin
            viol_code = 3'd7;
            viol_side = low_side(bad_ord);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RECOVER: if (timer == MIN_R) state_nxt = MONITOR;
            MONITOR: if (viol_code != 3'd0) state_nxt = FAULT;
            FAULT:   if (bus.clr) state_nxt = RECOVER;
            default: state_nxt = RECOVER;
        endcase
    end

    assign stay_mon    = (state == MONITOR) && (state_nxt == MONITOR);
    assign enter_fault = (state == MONITOR) && (state_nxt == FAULT);

`ifdef FLASH_EN
    localparam logic [CW-1:0] FH_LAST = CW'(FLASH_HALF - 1);

    logic [CW-1:0] flash_cnt;
    logic [CW-1:0] flash_cnt_nxt;
    logic          flash_on;
    logic          flash_on_nxt;

    // Outside FAULT the flash restarts so the first FAULT cycle is lit.
    always_comb begin
        flash_cnt_nxt = '0;
        flash_on_nxt  = 1'b1;
        if (state == FAULT) begin
            if (flash_cnt == FH_LAST) begin
                flash_on_nxt = ~flash_on;
            end else begin
                flash_cnt_nxt = flash_cnt + ONE;
                flash_on_nxt  = flash_on;
            end
        end
    end

    always_ff @(posedge clkdiv) begin
        if (rst) begin
            flash_cnt <= '0;
            flash_on  <= 1'b1;
        end else begin
            flash_cnt <= flash_cnt_nxt;
            flash_on  <= flash_on_nxt;
        end
    end

    assign fault_ro = flash_on_nxt ? ALL : 4'h0;
`else
    assign fault_ro = ALL;
`endif

    always_ff @(posedge clkdiv) begin
        if (rst) begin
            state   <= RECOVER;
            timer   <= '0;
            pR      <= ALL;
            pG      <= 4'h0;
            pO      <= 4'h0;
            ro_q    <= ALL;
            go_q    <= 4'h0;
            oo_q    <= 4'h0;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            side_q  <= 2'd0;
            for (int i = 0; i < 4; i++) cnt[i] <= ONE;
        end else begin
            state <= state_nxt;

            if ((state == RECOVER) && (state_nxt == RECOVER)) begin
                if (!all_red)
                    timer <= '0;
                else if (timer != CNT_MAX)
                    timer <= timer + ONE;
            end else begin
                timer <= '0;
            end

            // History restarts from all-red whenever monitoring (re)starts.
            if (stay_mon) begin
                pR <= bus.R;
                pG <= bus.G;
                pO <= bus.O;
                for (int i = 0; i < 4; i++) begin
                    if ({bus.R[i], bus.G[i], bus.O[i]} != {pR[i], pG[i], pO[i]})
                        cnt[i] <= ONE;
                    else if (cnt[i] != CNT_MAX)
                        cnt[i] <= cnt[i] + ONE;
                end
            end else begin
                pR <= ALL;
                pG <= 4'h0;
                pO <= 4'h0;
                for (int i = 0; i < 4; i++) cnt[i] <= ONE;
            end

            if (stay_mon) begin
                ro_q <= bus.R;
                go_q <= bus.G;
                oo_q <= bus.O;
            end else begin
                ro_q <= (state_nxt == FAULT) ? fault_ro : ALL;
                go_q <= 4'h0;
                oo_q <= 4'h0;
            end

            fault_q <= (state_nxt == FAULT);
            if (enter_fault) begin
                code_q <= viol_code;
                side_q <= viol_side;
            end else if (state_nxt != FAULT) begin
                code_q <= 3'd0;
                side_q <= 2'd0;
            end
        end
    end

    assign bus.Ro         = ro_q;
    assign bus.Go         = go_q;
    assign bus.Oo         = oo_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.fault_side = side_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed scenarios plus randomized lamp traffic against a history-based model.
// Build with +define+FLASH_EN to exercise the flashing fault aspect.
module tb_tlc_conflict_monitor;

    localparam int MIN_GREEN  = 5;
    localparam int MIN_AMBER  = 3;
    localparam int MIN_ALLRED = 4;
    localparam int FLASH_HALF = 4;
    localparam int M_MON = 0;
    localparam int M_FLT = 1;
    localparam int M_REC = 2;
    localparam logic [11:0] ALLRED = 12'hF00;
    localparam logic [2:0]  A_R = 3'b100;
    localparam logic [2:0]  A_G = 3'b010;
    localparam logic [2:0]  A_O = 3'b001;

    logic clkdiv = 1'b0;
    logic rst    = 1'b1;

    tlc_conflict_monitor_if bus ();

    tlc_conflict_monitor dut (
        .clkdiv (clkdiv),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clkdiv = ~clkdiv;

    int n_checks = 0;
    int n_fail   = 0;

    int         mode = M_REC;
    int         run  = 0;
    int         fcyc = 0;
    logic [3:0] e_ro = 4'hF;
    logic [3:0] e_go = 4'h0;
    logic [3:0] e_oo = 4'h0;
    logic       e_fault = 1'b0;
    logic [2:0] e_code = 3'd0;
    logic [1:0] e_side = 2'd0;
    logic [11:0] hist [$];

    int gside = 0;
    int gphase = 0;
    int glen = 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Aspect of side s as {red, green, amber}; v packs {R, G, O}.
    function automatic logic [2:0] asp(input logic [11:0] v, input int s);
        return {v[8+s], v[4+s], v[s]};
    endfunction

    function automatic logic [11:0] mk(input int s, input logic [2:0] a);
        logic [11:0] v;
        v = ALLRED;
        v[8+s] = a[2];
        v[4+s] = a[1];
        v[s]   = a[0];
        return v;
    endfunction

    // Length of the current run of identical aspects on side s.
    function automatic int run_len(input int s);
        logic [2:0] last;
        logic [2:0] a;
        int n;
        n = 0;
        last = asp(hist[hist.size()-1], s);
        for (int j = hist.size() - 1; j >= 0; j--) begin
            a = asp(hist[j], s);
            if (a != last) break;
            n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int violation(input logic [11:0] v);
        logic [2:0] a;
        logic [2:0] p;
        int ngo;
        int n;
        bit hit;
        ngo = 0;
        for (int s = 0; s < 4; s++) begin
            a = asp(v, s);
            if (a[1] || a[0]) ngo++;
        end
        for (int code = 1; code <= 7; code++) begin
            for (int s = 0; s < 4; s++) begin
                a = asp(v, s);
                p = asp(hist[hist.size()-1], s);
                n = run_len(s);
                case (code)
                    1: hit = $countones(a) > 1;
                    2: hit = (a == 3'b000);
                    3: hit = (ngo > 1) && (a[1] || a[0]);
                    4: hit = (p == A_G) && (a == A_R);
                    5: hit = (p == A_O) && (a != A_O) && (n < MIN_AMBER);
                    6: hit = (p == A_G) && (a != A_G) && (n < MIN_GREEN);
                    default: hit = ((p == A_R) && (a == A_O)) ||
                                   ((p == A_O) && (a == A_G));
                endcase
                if (hit) return code * 4 + s;
            end
        end
        return 0;
    endfunction

    function automatic logic [3:0] flash_ro(input int k);
`ifdef FLASH_EN
        return ((((k - 1) / FLASH_HALF) % 2) == 0) ? 4'hF : 4'h0;
`else
        return (k > 0) ? 4'hF : 4'hF;
`endif
    endfunction

    task automatic model_edge(input logic [11:0] v, input logic c, input logic rs);
        int vi;
        if (rs) begin
            mode = M_REC;
            run = 0;
            e_ro = 4'hF;
            e_go = 4'h0;
            e_oo = 4'h0;
            e_fault = 1'b0;
            e_code = 3'd0;
            e_side = 2'd0;
            hist.delete();
            return;
        end
        case (mode)
            M_REC: begin
                e_ro = 4'hF;
                e_go = 4'h0;
                e_oo = 4'h0;
                if (run >= MIN_ALLRED) begin
                    mode = M_MON;
                    run = 0;
                    hist.delete();
                    hist.push_back(ALLRED);
                end else if (v == ALLRED) begin
                    run++;
                end else begin
                    run = 0;
                end
            end
            M_MON: begin
                vi = violation(v);
                if (vi != 0) begin
                    mode = M_FLT;
                    e_code = 3'(vi / 4);
                    e_side = 2'(vi % 4);
                    e_fault = 1'b1;
                    fcyc = 1;
                    e_ro = flash_ro(fcyc);
                    e_go = 4'h0;
                    e_oo = 4'h0;
                end else begin
                    e_ro = v[11:8];
                    e_go = v[7:4];
                    e_oo = v[3:0];
                    hist.push_back(v);
                    if (hist.size() > 300) void'(hist.pop_front());
                end
            end
            default: begin
                if (c) begin
                    mode = M_REC;
                    run = 0;
                    e_fault = 1'b0;
                    e_code = 3'd0;
                    e_side = 2'd0;
                    e_ro = 4'hF;
                end else begin
                    fcyc++;
                    e_ro = flash_ro(fcyc);
                end
            end
        endcase
    endtask

    task automatic step(input logic [11:0] v, input logic c = 1'b0,
                        input logic rs = 1'b0);
        bus.R = v[11:8];
        bus.G = v[7:4];
        bus.O = v[3:0];
        bus.clr = c;
        rst = rs;
        @(posedge clkdiv);
        model_edge(v, c, rs);
        @(negedge clkdiv);
        check("Ro", bus.Ro, e_ro);
        check("Go", bus.Go, e_go);
        check("Oo", bus.Oo, e_oo);
        check("fault", bus.fault, e_fault);
        check("fault_code", bus.fault_code, e_code);
        check("fault_side", bus.fault_side, e_side);
    endtask

    task automatic show(input int s, input logic [2:0] a, input int n);
        repeat (n) step(mk(s, a));
    endtask

    task automatic to_monitor();
        if (mode == M_FLT) step(ALLRED, 1'b1);
        for (int i = 0; i < 12 && mode != M_MON; i++) step(ALLRED);
    endtask

    task automatic gen_next(output logic [11:0] v);
        case (gphase)
            0: begin
                v = ALLRED;
                glen--;
                if (glen <= 0) begin
                    gside = $urandom_range(0, 3);
                    gphase = 1;
                    glen = $urandom_range(3, 7);
                end
            end
            1: begin
                v = mk(gside, A_G);
                glen--;
                if (glen <= 0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        gphase = 0;
                        glen = $urandom_range(1, 2);
                    end else begin
                        gphase = 2;
                        glen = $urandom_range(1, 4);
                    end
                end
            end
            default: begin
                v = mk(gside, A_O);
                glen--;
                if (glen <= 0) begin
                    gphase = 0;
                    glen = $urandom_range(1, 2);
                end
            end
        endcase
    endtask

    initial begin
        bus.R = 4'hF;
        bus.G = 4'h0;
        bus.O = 4'h0;
        bus.clr = 1'b0;

        // Reset, recovery, then a clean two-side cycle
        step(ALLRED, 1'b0, 1'b1);
        step(ALLRED, 1'b0, 1'b1);
        to_monitor();
        show(0, A_G, 5);
        show(0, A_O, 3);
        show(0, A_R, 1);
        show(1, A_G, 5);
        show(1, A_O, 3);
        show(1, A_R, 1);

        // Two greens at once, held in FAULT long enough to see any flashing
        step(12'hA50);
        repeat (10) step(12'hA50);

        // Recovery with a dark cycle breaking the all-red run
        step(ALLRED, 1'b1);
        step(ALLRED);
        step(ALLRED);
        step(mk(0, 3'b000));
        to_monitor();

        // Skipped amber, then short amber, on side 2
        show(2, A_G, 6);
        show(2, A_R, 1);
        to_monitor();
        show(2, A_G, 6);
        show(2, A_O, 2);
        show(2, A_R, 1);
        to_monitor();

        // Red and green together on side 1
        step(mk(1, 3'b110));
        repeat (3) step(12'hA50);

        // Reset while latched in FAULT
        step(ALLRED, 1'b0, 1'b1);
        to_monitor();

        gphase = 0;
        glen = 1;
        for (int k = 0; k < 4000; k++) begin
            logic [11:0] v;
            logic c;
            logic rs;
            int prev_mode;
            rs = ($urandom_range(0, 299) == 0);
            if (mode == M_REC) begin
                v = ($urandom_range(0, 9) == 0) ? 12'($urandom) : ALLRED;
            end else begin
                gen_next(v);
                if ($urandom_range(0, 24) == 0) v = 12'($urandom);
            end
            c = (mode == M_FLT) ? ($urandom_range(0, 3) == 0)
                                : ($urandom_range(0, 7) == 0);
            prev_mode = mode;
            step(v, c, rs);
            if (mode == M_MON && prev_mode != M_MON) begin
                gphase = 0;
                glen = 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
